// File: rtl/detect_pulse_gen_if.sv
// Sample-in / detect-out bundle for one microphone channel.
// master = sample front-end side, slave = detect_pulse_gen.
interface detect_pulse_gen_if #(
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 8
);
  logic                       en;
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0]        threshold;
  logic                       detect;
  logic                       busy;
  logic [CNT_W-1:0]           event_count;

  modport master (
    output en,
    output sample_valid,
    output sample,
    output threshold,
    input  detect,
    input  busy,
    input  event_count
  );

  modport slave (
    input  en,
    input  sample_valid,
    input  sample,
    input  threshold,
    output detect,
    output busy,
    output event_count
  );
endinterface

// File: rtl/detect_pulse_gen.sv
// Magnitude-threshold detector: CONFIRM qualifying samples fire one
// fixed-width detect pulse, followed by a blind holdoff window.
module detect_pulse_gen #(
  parameter int SAMPLE_W       = 16,
  parameter int CONFIRM        = 4,
  parameter int PULSE_CYCLES   = 8,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input logic               clk,
  input logic               rst,
  detect_pulse_gen_if.slave bus
);

  localparam int MAX_CP =
    (CONFIRM > PULSE_CYCLES) ? CONFIRM : PULSE_CYCLES;
  localparam int MAXP =
    (MAX_CP > HOLDOFF_CYCLES) ? MAX_CP : HOLDOFF_CYCLES;
  localparam int CW = $clog2(MAXP + 1);

  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [CW-1:0] CONF_LAST = CW'(CONFIRM - 1);
  localparam logic [CW-1:0] P_END     = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] H_END     = CW'(HOLDOFF_CYCLES);

  localparam logic [CNT_W-1:0]    ONE_N = CNT_W'(1);
  localparam logic [SAMPLE_W-1:0] ONE_S = SAMPLE_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONF,
    S_PULSE,
    S_HOLD
  } state_t;

  state_t           state;
  logic [CW-1:0]    conf;
  logic [CW-1:0]    tmr;
  logic             detect_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;

  logic [SAMPLE_W-1:0] raw;
  logic [SAMPLE_W-1:0] mag;
  logic                qual;

  // Unsigned negate: -2^(W-1) lands on 2^(W-1) without overflow
  assign raw  = bus.sample;
  assign mag  = raw[SAMPLE_W-1] ? (~raw + ONE_S) : raw;
  assign qual = bus.sample_valid && (mag >= bus.threshold);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      conf     <= '0;
      tmr      <= '0;
      detect_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (!bus.en) begin
      state    <= S_IDLE;
      conf     <= '0;
      tmr      <= '0;
      detect_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state)
        // conf is 0 in IDLE, so CONFIRM==1 fires straight from IDLE
        S_IDLE, S_CONF: begin
          if (qual) begin
            busy_q <= 1'b1;
            if (conf == CONF_LAST) begin
              state    <= S_PULSE;
              conf     <= '0;
              tmr      <= ONE_C;
              detect_q <= 1'b1;
              cnt_q    <= cnt_q + ONE_N;
            end else begin
              state <= S_CONF;
              conf  <= conf + ONE_C;
            end
          end else if (bus.sample_valid) begin
            state  <= S_IDLE;
            conf   <= '0;
            busy_q <= 1'b0;
          end
        end
        S_PULSE: begin
          if (tmr == P_END) begin
            detect_q <= 1'b0;
            if (HOLDOFF_CYCLES == 0) begin
              state  <= S_IDLE;
              tmr    <= '0;
              busy_q <= 1'b0;
            end else begin
              state <= S_HOLD;
              tmr   <= ONE_C;
            end
          end else begin
            tmr <= tmr + ONE_C;
          end
        end
        S_HOLD: begin
          if (tmr == H_END) begin
            state  <= S_IDLE;
            tmr    <= '0;
            busy_q <= 1'b0;
          end else begin
            tmr <= tmr + ONE_C;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.detect      = detect_q;
  assign bus.busy        = busy_q;
  assign bus.event_count = cnt_q;

endmodule

// File: doc/detect_pulse_gen.md
Name: detect_pulse_gen

Overview:
- Generates the `detect` strobe that the Timer block captures. It is the producer end of the `detect` interface.
- Takes signed microphone samples and compares the sample magnitude against a runtime threshold. It requires CONFIRM consecutive qualifying samples before acting.
- On confirmation it emits a `detect` pulse of fixed length, then enters a holdoff window so one acoustic event yields exactly one timer capture.
- Sits between the sample front-end and the Timer, one instance per microphone channel.

Parameters:
- SAMPLE_W, 16, sample width in bits (signed two's complement).
- CONFIRM, 4, consecutive qualifying valid samples required to fire; must be >= 1.
- PULSE_CYCLES, 8, width of the `detect` high pulse in clk cycles; must be >= 1.
- HOLDOFF_CYCLES, 64, clk cycles of blind time after the pulse; 0 allowed.
- CNT_W, 8, width of the event counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  block enable.
- sample_valid  input  1  `sample` is valid this cycle.
- sample  input  SAMPLE_W  signed sample.
- threshold  input  SAMPLE_W  unsigned magnitude threshold; sampled every valid cycle, not latched.
- detect  output  1  registered pulse to Timer `detect`.
- busy  output  1  high whenever the FSM is not in IDLE.
- event_count  output  CNT_W  number of pulses issued; wraps modulo 2^CNT_W.

Behaviour:
- Reset: rst high at a rising edge sets state IDLE, confirm counter 0, timer counter 0, detect 0, busy 0, event_count 0.
  - Reset has priority over everything and aborts any pulse or holdoff in progress; detect is 0 after that edge.
- Magnitude:
  - mag = |sample|, computed in SAMPLE_W bits unsigned.
  - The most negative value (-2^(SAMPLE_W-1)) maps to 2^(SAMPLE_W-1), with no overflow.
  - A sample qualifies when sample_valid=1 and mag >= threshold. threshold=0 makes every valid sample qualify.
- en=0: at the next edge the state goes to IDLE, the confirm count clears and detect drops to 0. event_count holds. This applies mid-pulse too, so a truncated pulse is legal.
- States:
  - IDLE:
    - A qualifying sample sets confirm=1.
    - If CONFIRM==1, go to PULSE at the same edge. Otherwise go to CONFIRM.
    - Non-qualifying or invalid cycles stay in IDLE.
  - CONFIRM:
    - A qualifying sample increments confirm. When the count reaches CONFIRM, go to PULSE.
    - A valid, non-qualifying sample returns to IDLE with confirm=0.
    - sample_valid=0 cycles hold state and count; gaps do not break the run.
  - PULSE:
    - detect=1 for exactly PULSE_CYCLES consecutive cycles.
    - event_count increments once, at the edge entering PULSE.
    - Samples are ignored.
    - After PULSE_CYCLES cycles, go to HOLDOFF, or to IDLE if HOLDOFF_CYCLES==0.
  - HOLDOFF: samples are ignored for exactly HOLDOFF_CYCLES cycles, then go to IDLE. detect=0.
- Latency:
  - Call the edge at which the CONFIRM-th qualifying sample is registered edge k.
  - detect reads 1 from just after edge k through the edge k+PULSE_CYCLES, where it returns to 0.
  - busy is 1 after the first qualifying sample's edge. It is 0 again after the edge k+PULSE_CYCLES+HOLDOFF_CYCLES.
- Re-arm: the first sample eligible for a new confirmation run is the one presented at the edge following the return to IDLE.
- event_count wrap: 2^CNT_W-1 rolls over to 0 with no flag.
- Counter widths: internal counters are sized with $clog2 of the largest parameter + 1; no truncation is allowed.

Test Plan:
- Reset defaults: rst pulse with en=1 and no samples -> detect=0, busy=0, event_count=0; outputs stay idle.
- Basic fire:
  - Setup: threshold=100, samples 120, -150, 101, 100 valid on consecutive cycles.
  - Required: detect high for exactly 8 cycles starting the cycle after the 4th sample; busy low 72 cycles after that edge; event_count=1.
- Broken run and gaps:
  - Setup: samples 200, 200, 50, 200, 200, 200, with sample_valid=0 gaps of 3 cycles inserted between the last three.
  - Required: no pulse until the 4th consecutive qualifying sample after the 50 (i.e. a 7th sample 200 is needed); a single pulse then issues.
- Holdoff masking: after a pulse, drive continuous samples of 1000 -> no second pulse until HOLDOFF ends; the next pulse is exactly 4 valid samples after the return to IDLE.
- Edge values:
  - Setup: sample=-32768 with threshold=32768 (0x8000).
  - Required: qualifies and fires; threshold=0 with sample=0 also fires.
- Abort and wrap:
  - en drop at pulse cycle 3 -> detect=0 the next cycle, state IDLE.
  - rst mid-holdoff -> busy=0 next cycle.
  - Force 256 pulses -> event_count returns to 0.
